// File: rtl/pdq_pipe_pkg.sv
// Shared types and constants for the flow-controlled pipeline register.
// Occupancy is carried as a state encoding, so the word count can be decoded from it.
package pdq_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam int SKID_DEPTH = 2;
    localparam int COUNT_W    = $clog2(SKID_DEPTH + 1);

    // Number of words held in a given state.
    function automatic logic [COUNT_W-1:0] state_count(input skid_state_t s);
        logic [COUNT_W-1:0] n;
        case (s)
            BUSY:    n = COUNT_W'(1);
            FULL:    n = COUNT_W'(2);
            default: n = '0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pipelined_skid_register_if.sv
// Handshake bundle for the skid register: upstream valid/ready/data,
// downstream valid/ready/data, and the occupancy count.
interface pipelined_skid_register_if
    import pdq_pipe_pkg::*;
#(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0]   I_data;
    logic               I_valid;
    logic               I_ready;
    logic [WIDTH-1:0]   O_data;
    logic               O_valid;
    logic               O_ready;
    logic [COUNT_W-1:0] O_count;

    // The register block itself.
    modport slave (
        input  I_data, I_valid, O_ready,
        output I_ready, O_data, O_valid, O_count
    );

    // Whatever drives the block and consumes its output.
    modport master (
        output I_data, I_valid, O_ready,
        input  I_ready, O_data, O_valid, O_count
    );
endinterface

// File: rtl/skid_data_reg.sv
// WIDTH-bit data register with load enable and synchronous reset to INIT.
module skid_data_reg #(
    parameter int             WIDTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             i_srst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q_reg;

    always_ff @(posedge clk) begin
        if (i_srst) begin
            r_q_reg <= INIT;
        end else if (i_load) begin
            r_q_reg <= i_d;
        end
    end

    assign o_q = r_q_reg;
endmodule

// File: rtl/pipelined_skid_register.sv
// Two-word valid/ready pipeline register: a main register presented downstream
// plus a skid register that absorbs one word when the output stalls.
module pipelined_skid_register
    import pdq_pipe_pkg::*;
#(
    parameter int               WIDTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic                        CLK,
    input  logic                        RESET,
    pipelined_skid_register_if.slave    bus
);
    skid_state_t      r_state_reg;
    skid_state_t      w_state_next;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_main_load;
    logic             w_skid_load;
    logic             w_main_from_skid;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] w_main_q;
    logic [WIDTH-1:0] w_skid_q;

    assign bus.I_ready = (r_state_reg != FULL) & ~RESET;
    assign bus.O_valid = (r_state_reg != EMPTY);
    assign bus.O_count = state_count(r_state_reg);
    assign bus.O_data  = w_main_q;

    assign w_in_xfer  = bus.I_valid & bus.I_ready;
    assign w_out_xfer = bus.O_valid & bus.O_ready;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state_reg <= EMPTY;
        end else begin
            r_state_reg <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state_reg;
        w_main_load      = 1'b0;
        w_skid_load      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state_reg)
            EMPTY: begin
                if (w_in_xfer) begin
                    w_main_load  = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_main_load = 1'b1;
                end else if (w_in_xfer) begin
                    // Output stalled: park the new word behind the main one.
                    w_skid_load  = 1'b1;
                    w_state_next = FULL;
                end else if (w_out_xfer) begin
                    w_state_next = EMPTY;
                end
            end
            FULL: begin
                if (w_out_xfer) begin
                    w_main_load      = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_state_next     = BUSY;
                end
            end
            default: begin
                w_state_next = EMPTY;
            end
        endcase
    end

    assign w_main_d = w_main_from_skid ? w_skid_q : bus.I_data;

    skid_data_reg #(
        .WIDTH (WIDTH),
        .INIT  (INIT)
    ) u_main (
        .clk    (CLK),
        .i_srst (RESET),
        .i_load (w_main_load),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    skid_data_reg #(
        .WIDTH (WIDTH),
        .INIT  (INIT)
    ) u_skid (
        .clk    (CLK),
        .i_srst (RESET),
        .i_load (w_skid_load),
        .i_d    (bus.I_data),
        .o_q    (w_skid_q)
    );
endmodule

// File: tb/tb_pipelined_skid_register.sv
// Directed and randomized checks of the skid register against hand-computed
// values and a reference queue.
module tb_pipelined_skid_register;
    localparam int         WIDTH = 8;
    localparam logic [7:0] INIT  = 8'hA5;

    logic CLK;
    logic RESET;
    int   n_vec;
    int   n_bad;

    pipelined_skid_register_if #(.WIDTH(WIDTH)) bus ();

    pipelined_skid_register #(
        .WIDTH (WIDTH),
        .INIT  (INIT)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        bus.I_valid = 1'b0;
        bus.I_data  = 8'h00;
        bus.O_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            n_vec++;
            if (bus.I_ready !== 1'b0 || bus.O_valid !== 1'b0 ||
                bus.O_count !== 2'd0 || bus.O_data !== INIT) begin
                n_bad++;
                $display("FAIL reset cyc%0d: ready=%b valid=%b count=%0d data=%h, want 0 0 0 %h",
                         c, bus.I_ready, bus.O_valid, bus.O_count, bus.O_data, INIT);
            end
        end
        RESET = 1'b0;
        #1;
        n_vec++;
        if (bus.I_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release: I_ready=%b want 1", bus.I_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_streaming();
        logic [7:0] v;
        bus.O_ready = 1'b1;
        bus.I_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            v = 8'(k);
            bus.I_data = v;
            step();
            n_vec++;
            if (bus.O_data !== v || bus.O_valid !== 1'b1 || bus.O_count !== 2'd1 ||
                bus.I_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL stream%0d: data=%h valid=%b count=%0d ready=%b, want %h 1 1 1",
                         k, bus.O_data, bus.O_valid, bus.O_count, bus.I_ready, v);
            end
        end
        bus.I_valid = 1'b0;
        step();
        n_vec++;
        if (bus.O_valid !== 1'b0 || bus.O_count !== 2'd0 || bus.O_data !== 8'h04) begin
            n_bad++;
            $display("FAIL stream_drain: valid=%b count=%0d data=%h, want 0 0 04",
                     bus.O_valid, bus.O_count, bus.O_data);
        end
        $display("test_streaming done");
    endtask

    // Fill both registers with O_ready low; leaves the block FULL with 11/22.
    task automatic fill_11_22();
        bus.O_ready = 1'b0;
        bus.I_valid = 1'b1;
        bus.I_data  = 8'h11;
        step();
        bus.I_data  = 8'h22;
        step();
        bus.I_valid = 1'b0;
    endtask

    task automatic test_stall_fill();
        fill_11_22();
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (bus.O_count !== 2'd2 || bus.I_ready !== 1'b0 || bus.O_data !== 8'h11 ||
                bus.O_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL stall_hold%0d: count=%0d ready=%b data=%h valid=%b, want 2 0 11 1",
                         c, bus.O_count, bus.I_ready, bus.O_data, bus.O_valid);
            end
            step();
        end
        bus.O_ready = 1'b1;
        step();
        n_vec++;
        if (bus.O_data !== 8'h22 || bus.O_count !== 2'd1 || bus.I_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_drain1: data=%h count=%0d ready=%b, want 22 1 1",
                     bus.O_data, bus.O_count, bus.I_ready);
        end
        step();
        n_vec++;
        if (bus.O_count !== 2'd0 || bus.O_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_drain2: count=%0d valid=%b, want 0 0", bus.O_count, bus.O_valid);
        end
        $display("test_stall_fill done");
    endtask

    task automatic test_blocked_input();
        logic [7:0] seen [$];
        fill_11_22();
        bus.I_valid = 1'b1;
        bus.I_data  = 8'h33;
        step();
        step();
        n_vec++;
        if (bus.O_count !== 2'd2 || bus.O_data !== 8'h11) begin
            n_bad++;
            $display("FAIL blocked_hold: count=%0d data=%h, want 2 11", bus.O_count, bus.O_data);
        end
        bus.I_valid = 1'b0;
        bus.O_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (bus.O_valid === 1'b1) seen.push_back(bus.O_data);
            step();
        end
        n_vec++;
        if (seen.size() != 2 || seen[0] !== 8'h11 || seen[1] !== 8'h22) begin
            n_bad++;
            $display("FAIL blocked_drain: got %0d words (%p), want 2 words 11 22", seen.size(), seen);
        end
        $display("test_blocked_input done");
    endtask

    task automatic test_mid_reset();
        fill_11_22();
        RESET = 1'b1;
        bus.O_ready = 1'b1;
        bus.I_valid = 1'b1;
        bus.I_data  = 8'h77;
        step();
        n_vec++;
        if (bus.O_valid !== 1'b0 || bus.O_count !== 2'd0 || bus.O_data !== INIT ||
            bus.I_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset: valid=%b count=%0d data=%h ready=%b, want 0 0 %h 0",
                     bus.O_valid, bus.O_count, bus.O_data, bus.I_ready, INIT);
        end
        RESET = 1'b0;
        bus.I_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_vec++;
            if (bus.O_valid !== 1'b0 || bus.O_data !== INIT) begin
                n_bad++;
                $display("FAIL midreset_after%0d: valid=%b data=%h, want 0 %h",
                         c, bus.O_valid, bus.O_data, INIT);
            end
        end
        $display("test_mid_reset done");
    endtask

    task automatic test_random();
        logic [7:0] q [$];
        int         errs;
        int         words;
        logic       m_ready;
        logic       m_valid;
        errs  = 0;
        words = 0;
        for (int c = 0; c < 10000; c++) begin
            bus.I_valid = 1'($urandom_range(0, 1));
            bus.O_ready = 1'($urandom_range(0, 1));
            bus.I_data  = 8'($urandom);
            m_ready = (q.size() < 2);
            m_valid = (q.size() > 0);
            n_vec++;
            if (bus.O_count !== 2'(q.size()) || bus.I_ready !== m_ready ||
                bus.O_valid !== m_valid || (m_valid && bus.O_data !== q[0])) begin
                n_bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random cyc%0d: count=%0d ready=%b valid=%b data=%h, want %0d %b %b %h",
                             c, bus.O_count, bus.I_ready, bus.O_valid, bus.O_data,
                             q.size(), m_ready, m_valid, m_valid ? q[0] : 8'h00);
            end
            if (m_valid && bus.O_ready) begin
                void'(q.pop_front());
                words++;
            end
            if (m_ready && bus.I_valid) q.push_back(bus.I_data);
            step();
        end
        bus.I_valid = 1'b0;
        $display("test_random done: %0d words delivered", words);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        RESET = 1'b1;
        bus.I_valid = 1'b0;
        bus.I_data  = '0;
        bus.O_ready = 1'b0;
        #2;
        test_reset();
        test_streaming();
        test_stall_fill();
        test_blocked_input();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
